// File: rtl/multicycle_ctrl_if.sv
// Memory handshake between the multicycle sequencer (master) and the
// single-ported memory (slave).
interface multicycle_ctrl_if;
  logic mem_req;
  logic mem_we;
  logic addr_sel;
  logic mem_ready;

  modport master (
    output mem_req,
    output mem_we,
    output addr_sel,
    input  mem_ready
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  addr_sel,
    output mem_ready
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the femtoRV32 datapath,
// with memory-timeout and illegal-opcode detection and a retire counter.
module multicycle_ctrl #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  input  logic [6:0]  opcode,
  multicycle_ctrl_if.master bus,
  output logic        ir_load,
  output logic        alu_load,
  output logic        mdr_load,
  output logic        pc_load,
  output logic        rf_we,
  output logic        wb_sel,
  output logic [2:0]  state,
  output logic        busy,
  output logic        bus_err,
  output logic        illegal,
  output logic [31:0] instr_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_wait;
  logic [7:0]  w_wait_next;
  logic        r_bus_err;
  logic        r_illegal;
  logic [31:0] r_instr_count;

  logic w_mem_req, w_mem_we, w_addr_sel;
  logic w_ir_load, w_alu_load, w_mdr_load, w_pc_load, w_rf_we, w_wb_sel;
  logic w_set_bus_err, w_set_illegal;
  logic w_is_load, w_is_store, w_is_branch, w_is_system, w_legal;

  assign w_is_load   = (opcode == OP_LOAD);
  assign w_is_store  = (opcode == OP_STORE);
  assign w_is_branch = (opcode == OP_BRANCH);
  assign w_is_system = (opcode == OP_SYSTEM);
  assign w_legal     = opcode inside {7'b0110011, 7'b0010011, 7'b0000011,
                                      7'b0100011, 7'b1100011, 7'b1101111,
                                      7'b1100111, 7'b0110111, 7'b0010111};

  always_comb begin
    w_next        = r_state;
    w_wait_next   = '0;
    w_mem_req     = 1'b0;
    w_mem_we      = 1'b0;
    w_addr_sel    = 1'b0;
    w_ir_load     = 1'b0;
    w_alu_load    = 1'b0;
    w_mdr_load    = 1'b0;
    w_pc_load     = 1'b0;
    w_rf_we       = 1'b0;
    w_wb_sel      = 1'b0;
    w_set_bus_err = 1'b0;
    w_set_illegal = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (run) w_next = S_FETCH;
      end
      S_FETCH: begin
        w_mem_req = 1'b1;
        if (bus.mem_ready) begin
          w_ir_load = 1'b1;
          w_next    = S_DECODE;
        end else if (r_wait == LP_WAIT_LAST) begin
          w_set_bus_err = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_DECODE: begin
        if (w_is_system) begin
          w_next = S_HALT;
        end else if (!w_legal) begin
          w_set_illegal = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_next = S_EXEC;
        end
      end
      S_EXEC: begin
        w_alu_load = 1'b1;
        if (w_is_load || w_is_store) begin
          w_next = S_MEM;
        end else if (w_is_branch) begin
          w_pc_load = 1'b1;
          w_next    = run ? S_FETCH : S_IDLE;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        w_mem_req  = 1'b1;
        w_addr_sel = 1'b1;
        w_mem_we   = w_is_store;
        // Ready wins over the timeout compare, matching FETCH.
        if (bus.mem_ready) begin
          if (w_is_load) begin
            w_mdr_load = 1'b1;
            w_next     = S_WB;
          end else begin
            w_pc_load = 1'b1;
            w_next    = run ? S_FETCH : S_IDLE;
          end
        end else if (r_wait == LP_WAIT_LAST) begin
          w_set_bus_err = 1'b1;
          w_next        = S_HALT;
        end else begin
          w_wait_next = r_wait + 8'd1;
        end
      end
      S_WB: begin
        w_rf_we   = 1'b1;
        w_pc_load = 1'b1;
        w_wb_sel  = w_is_load;
        w_next    = run ? S_FETCH : S_IDLE;
      end
      S_HALT: begin
        w_next = S_HALT;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      r_bus_err     <= 1'b0;
      r_illegal     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= w_wait_next;
      if (w_set_bus_err) r_bus_err <= 1'b1;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_pc_load)     r_instr_count <= r_instr_count + 32'd1;
    end
  end

  // Strobes are masked by rst so the reset cycle itself issues nothing.
  assign bus.mem_req  = w_mem_req  & ~rst;
  assign bus.mem_we   = w_mem_we   & ~rst;
  assign bus.addr_sel = w_addr_sel & ~rst;
  assign ir_load      = w_ir_load  & ~rst;
  assign alu_load     = w_alu_load & ~rst;
  assign mdr_load     = w_mdr_load & ~rst;
  assign pc_load      = w_pc_load  & ~rst;
  assign rf_we        = w_rf_we    & ~rst;
  assign wb_sel       = w_wb_sel   & ~rst;
  assign busy         = ~rst & (r_state != S_IDLE) & (r_state != S_HALT);

  assign state       = r_state;
  assign bus_err     = r_bus_err;
  assign illegal     = r_illegal;
  assign instr_count = r_instr_count;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instructions are planned phase by phase into an
// expected cycle trace, which is replayed against the DUT.
module tb_multicycle_ctrl;

  localparam int unsigned TO = 4;

  localparam logic [2:0] ST_I = 3'd0, ST_F = 3'd1, ST_D = 3'd2, ST_E = 3'd3,
                         ST_M = 3'd4, ST_W = 3'd5, ST_H = 3'd6;

  localparam logic [8:0] REQ  = 9'b100000000, WE   = 9'b010000000,
                         ASEL = 9'b001000000, IRL  = 9'b000100000,
                         ALUL = 9'b000010000, MDRL = 9'b000001000,
                         PCL  = 9'b000000100, RFW  = 9'b000000010,
                         WBS  = 9'b000000001;

  localparam int K_ILL = 0, K_SYS = 1, K_BR = 2, K_LD = 3, K_ST = 4, K_OTH = 5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic [6:0]  opcode = '0;
  logic        ir_load, alu_load, mdr_load, pc_load, rf_we, wb_sel;
  logic [2:0]  state;
  logic        busy, bus_err, illegal;
  logic [31:0] instr_count;

  multicycle_ctrl_if bus_if ();

  multicycle_ctrl #(.TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .opcode      (opcode),
    .bus         (bus_if.master),
    .ir_load     (ir_load),
    .alu_load    (alu_load),
    .mdr_load    (mdr_load),
    .pc_load     (pc_load),
    .rf_we       (rf_we),
    .wb_sel      (wb_sel),
    .state       (state),
    .busy        (busy),
    .bus_err     (bus_err),
    .illegal     (illegal),
    .instr_count (instr_count)
  );

  always #5 clk = ~clk;

  logic [9:0] obs;
  assign obs = {bus_if.mem_req, bus_if.mem_we, bus_if.addr_sel, ir_load, alu_load,
                mdr_load, pc_load, rf_we, wb_sel, busy};

  typedef struct {
    logic       rv;
    logic       rdy;
    logic [6:0] op;
    logic [2:0] st;
    logic [9:0] sv;
    logic       pl;
    logic       be;
    logic       il;
  } ent_t;

  ent_t        q[$];
  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_cnt = '0;
  logic        exp_be = 1'b0;
  logic        exp_il = 1'b0;
  logic [6:0]  legal_ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                 7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                 7'b0010111};

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] rop();
    return 7'($urandom);
  endfunction

  // Run level on non-retire cycles: random, or held low for the final instruction.
  function automatic logic mid(input bit last);
    return last ? 1'b0 : rb();
  endfunction

  function automatic int kind(input logic [6:0] op);
    case (op)
      7'b1110011: return K_SYS;
      7'b1100011: return K_BR;
      7'b0000011: return K_LD;
      7'b0100011: return K_ST;
      7'b0110011, 7'b0010011, 7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111:
        return K_OTH;
      default: return K_ILL;
    endcase
  endfunction

  task automatic add(input logic [2:0] st, input logic [8:0] stb, input logic rdy,
                     input logic rv, input logic [6:0] op, input logic be, input logic il);
    ent_t e;
    e.st  = st;
    e.sv  = {stb, (st != ST_I) && (st != ST_H)};
    e.pl  = (stb & PCL) != '0;
    e.rdy = rdy;
    e.rv  = rv;
    e.op  = op;
    e.be  = be;
    e.il  = il;
    q.push_back(e);
  endtask

  task automatic add_halts();
    repeat (3) add(ST_H, '0, rb(), rb(), rop(), 1'b0, 1'b0);
  endtask

  task automatic add_idle(input int unsigned n_wait);
    repeat (n_wait) add(ST_I, '0, rb(), 1'b0, rop(), 1'b0, 1'b0);
    add(ST_I, '0, rb(), 1'b1, rop(), 1'b0, 1'b0);
  endtask

  task automatic plan_instr(input logic [6:0] op, input int unsigned wf, input int unsigned wm,
                            input bit last, output bit halted);
    int k;
    logic [8:0] ms;
    k = kind(op);
    halted = 1'b0;
    for (int unsigned i = 0; i < wf && i < TO; i++)
      add(ST_F, REQ, 1'b0, rb(), rop(), i == TO - 1, 1'b0);
    if (wf >= TO) begin add_halts(); halted = 1'b1; return; end
    add(ST_F, REQ | IRL, 1'b1, rb(), rop(), 1'b0, 1'b0);
    add(ST_D, '0, rb(), mid(last), op, 1'b0, k == K_ILL);
    if (k == K_ILL || k == K_SYS) begin add_halts(); halted = 1'b1; return; end
    if (k == K_BR) begin
      add(ST_E, ALUL | PCL, rb(), !last, op, 1'b0, 1'b0);
      return;
    end
    add(ST_E, ALUL, rb(), mid(last), op, 1'b0, 1'b0);
    if (k == K_LD || k == K_ST) begin
      ms = (k == K_ST) ? (REQ | WE | ASEL) : (REQ | ASEL);
      for (int unsigned i = 0; i < wm && i < TO; i++)
        add(ST_M, ms, 1'b0, mid(last), op, i == TO - 1, 1'b0);
      if (wm >= TO) begin add_halts(); halted = 1'b1; return; end
      if (k == K_ST) begin
        add(ST_M, ms | PCL, 1'b1, !last, op, 1'b0, 1'b0);
        return;
      end
      add(ST_M, ms | MDRL, 1'b1, mid(last), op, 1'b0, 1'b0);
    end
    add(ST_W, RFW | PCL | ((k == K_LD) ? WBS : 9'b0), rb(), !last, op, 1'b0, 1'b0);
  endtask

  // Replays up to n planned cycles, then discards the rest of the plan.
  task automatic run_trace(input int n);
    ent_t e;
    int   idx;
    idx = 0;
    while (q.size() > 0 && idx < n) begin
      e = q.pop_front();
      @(negedge clk);
      run = e.rv;
      bus_if.mem_ready = e.rdy;
      opcode = e.op;
      #1;
      n_checks++;
      if ({state, obs} !== {e.st, e.sv}) begin
        n_fail++;
        $display("FAIL trace[%0d] state/strobes: got st=%0d sv=%b, want st=%0d sv=%b",
                 idx, state, obs, e.st, e.sv);
      end
      n_checks++;
      if ({instr_count, bus_err, illegal} !== {exp_cnt, exp_be, exp_il}) begin
        n_fail++;
        $display("FAIL trace[%0d] count/flags: got cnt=%0d be=%b il=%b, want cnt=%0d be=%b il=%b",
                 idx, instr_count, bus_err, illegal, exp_cnt, exp_be, exp_il);
      end
      if (e.pl) exp_cnt = exp_cnt + 32'd1;
      if (e.be) exp_be = 1'b1;
      if (e.il) exp_il = 1'b1;
      idx++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    run = 1'b0;
    bus_if.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_cnt = '0;
    exp_be = 1'b0;
    exp_il = 1'b0;
    q.delete();
  endtask

  task automatic test_reset();
    @(negedge clk);
    #1;
    n_checks++;
    if ({state, obs, instr_count, bus_err, illegal} !== 47'd0) begin
      n_fail++;
      $display("FAIL reset_state: got st=%0d sv=%b cnt=%0d be=%b il=%b, want all zero",
               state, obs, instr_count, bus_err, illegal);
    end
    rst = 1'b0;
  endtask

  task automatic test_single(input string name, input logic [6:0] op,
                             input int unsigned wf, input int unsigned wm);
    bit h;
    do_reset();
    add_idle(0);
    plan_instr(op, wf, wm, 1'b1, h);
    if (!h) add(ST_I, '0, rb(), 1'b0, rop(), 1'b0, 1'b0);
    run_trace(1000);
    n_checks++;
    if (instr_count !== (h ? 32'd0 : 32'd1)) begin
      n_fail++;
      $display("FAIL %s count: got %0d, want %0d", name, instr_count, h ? 0 : 1);
    end
  endtask

  task automatic test_timeout();
    test_single("timeout", 7'b0110011, TO, 0);
    n_checks++;
    if ({state, bus_err, busy} !== {ST_H, 1'b1, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_halt: got st=%0d be=%b busy=%b, want st=6 be=1 busy=0",
               state, bus_err, busy);
    end
    do_reset();
    #1;
    n_checks++;
    if ({state, bus_err} !== {ST_I, 1'b0}) begin
      n_fail++;
      $display("FAIL timeout_clear: got st=%0d be=%b, want st=0 be=0", state, bus_err);
    end
  endtask

  task automatic test_illegal();
    test_single("illegal", 7'b0000000, 0, 0);
    n_checks++;
    if ({state, illegal} !== {ST_H, 1'b1}) begin
      n_fail++;
      $display("FAIL illegal_flag: got st=%0d il=%b, want st=6 il=1", state, illegal);
    end
    test_single("system", 7'b1110011, 0, 0);
    n_checks++;
    if ({state, illegal} !== {ST_H, 1'b0}) begin
      n_fail++;
      $display("FAIL system_halt: got st=%0d il=%b, want st=6 il=0", state, illegal);
    end
  endtask

  task automatic test_reset_in_mem();
    bit h;
    do_reset();
    add_idle(0);
    plan_instr(7'b0110011, 0, 0, 1'b0, h);
    plan_instr(7'b0000011, 0, 3, 1'b0, h);
    // idle + 4 ALU cycles + F/D/E + first MEM wait cycle
    run_trace(9);
    @(negedge clk);
    rst = 1'b1;
    run = 1'b1;
    bus_if.mem_ready = 1'b1;
    opcode = 7'b0000011;
    #1;
    n_checks++;
    if ({state, obs} !== {ST_M, 10'b0}) begin
      n_fail++;
      $display("FAIL rst_in_mem strobes: got st=%0d sv=%b, want st=4 sv=0", state, obs);
    end
    @(negedge clk);
    rst = 1'b0;
    run = 1'b0;
    #1;
    n_checks++;
    if ({state, obs, instr_count} !== {ST_I, 10'b0, 32'd0}) begin
      n_fail++;
      $display("FAIL rst_in_mem after: got st=%0d sv=%b cnt=%0d, want st=0 sv=0 cnt=0",
               state, obs, instr_count);
    end
  endtask

  task automatic test_random();
    bit          h;
    int unsigned ni, wf, wm, r;
    logic [6:0]  op;
    do_reset();
    repeat (30) begin
      h = 1'b0;
      add_idle($urandom_range(0, 2));
      ni = $urandom_range(1, 4);
      for (int unsigned k = 0; k < ni && !h; k++) begin
        r = $urandom_range(0, 19);
        if (r == 0)      op = 7'b1110011;
        else if (r == 1) op = rop();
        else             op = legal_ops[r % 9];
        wf = ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
        wm = ($urandom_range(0, 11) == 0) ? $urandom_range(TO, TO + 2) : $urandom_range(0, TO - 1);
        plan_instr(op, wf, wm, k == ni - 1, h);
      end
      if (!h) add(ST_I, '0, rb(), 1'b0, rop(), 1'b0, 1'b0);
      run_trace(100000);
      if (h) do_reset();
    end
  endtask

  initial begin
    bus_if.mem_ready = 1'b0;
    test_reset();
    test_single("alu", 7'b0110011, 0, 0);
    test_single("load_wait", 7'b0000011, 0, 3);
    test_single("store", 7'b0100011, 0, 0);
    test_single("branch", 7'b1100011, 2, 0);
    test_single("run_drop", 7'b0010011, 1, 0);
    test_timeout();
    test_illegal();
    test_reset_in_mem();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
